fp16_recip_seq: RTL and testbench

Sequential reciprocal unit: accepts an FP16 operand (1-5-10), returns its reciprocal as FP12 (1-5-6), correctly rounded to nearest-even. It complements the combinational FP12→FP16 inverse in the opposite format direction. It trades area for latency with a bit-serial restoring divider. It sits behind a valid/ready stream in the TPU normalisation path, feeding FP12 scale factors to the multiplier array.

---
 rtl/fp_pkg.sv | 72 +++++++
 rtl/fp_restoring_divstep.sv | 35 +++
 rtl/fp16_recip_seq.sv | 183 ++++++++++++++++++
 tb/tb_fp16_recip_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : fp_pkg                                                       |
// | Purpose   : Shared FP16 / FP12 field widths, constants, field-extract     |
// |             typedefs, FSM state type and the special-operand mapping      |
// |             used by the sequential reciprocal unit.                       |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package fp_pkg;

   // Field widths
   localparam int FP16_EXP_W = 5;
   localparam int FP16_MAN_W = 10;
   localparam int FP12_EXP_W = 5;
   localparam int FP12_MAN_W = 6;

   // Both formats share bias and all-ones exponent encoding
   localparam int                   FP_BIAS  = 15;
   localparam logic [FP16_EXP_W-1:0] EXP_ONES = 5'h1F;

   // FP12 constants
   localparam logic [11:0]           FP12_POS_INF       = 12'h7C0;
   localparam logic [11:0]           FP12_NEG_ZERO      = 12'h800;
   localparam logic [FP12_MAN_W-1:0] FP12_CANON_NAN_MAN = 6'b100000;

   // Divider datapath: remainder holds values up to 4.0 with 10 fraction bits,
   // divisor is the 11-bit significand {1, mant}.
   localparam int          REM_W    = 12;
   localparam int          DIV_W    = 11;
   localparam logic [11:0] REM_INIT = 12'h800;   // 2.0

   // Biased result exponent for 2/1.m * 2^(14-e): (2*bias - 1) - e
   localparam logic [6:0] EXP_RECIP_BASE = 7'(2 * FP_BIAS - 1);

   typedef struct packed {
      logic                  sign;
      logic [FP16_EXP_W-1:0] exp;
      logic [FP16_MAN_W-1:0] mant;
   } fp16_t;

   typedef struct packed {
      logic                  sign;
      logic [FP12_EXP_W-1:0] exp;
      logic [FP12_MAN_W-1:0] mant;
   } fp12_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIV   = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Reciprocal of a zero/subnormal (flushed), infinity or NaN operand.
   // Only meaningful when exp is 0 or all-ones; sign is always kept.
   function automatic fp12_t fp12_special(input fp16_t op);
      fp12_t r;
      r = '0;
      if (op.exp == '0) begin
         r = fp12_t'(FP12_POS_INF);
      end else if (op.mant == '0) begin
         r = fp12_t'(FP12_NEG_ZERO);
      end else begin
         r.exp  = EXP_ONES;
         r.mant = FP12_CANON_NAN_MAN;
      end
      r.sign = op.sign;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_restoring_divstep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : fp_restoring_divstep                                        |
// | Purpose   : One combinational step of a restoring divider.               |
// |             Produces one quotient bit and the doubled partial remainder. |
// | Ports     : rem      in  12  current partial remainder                   |
// |             divisor  in  11  divisor significand {1, mant}               |
// |             rem_next out 12  remainder for the next step                 |
// |             qbit     out  1  quotient bit for this step                  |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fp_restoring_divstep
   import fp_pkg::*;
(
   input  logic [REM_W-1:0] rem,
   input  logic [DIV_W-1:0] divisor,
   output logic [REM_W-1:0] rem_next,
   output logic             qbit
);

   logic [REM_W-1:0] divisor_ext;
   logic [REM_W-1:0] diff;
   logic [REM_W-1:0] kept;

   always_comb begin
      divisor_ext = {1'b0, divisor};
      qbit        = (rem >= divisor_ext);
      diff        = rem - divisor_ext;
      kept        = qbit ? diff : rem;
      // kept < divisor < 2.0, so the doubling never loses a set bit
      rem_next    = kept << 1;
   end

endmodule
`default_nettype wire

// File: rtl/fp16_recip_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : fp16_recip_seq                                              |
// | Purpose   : Sequential FP16 -> FP12 reciprocal, round-to-nearest-even,   |
// |             bit-serial restoring division behind valid/ready streams.    |
// | Ports     : clk       in   1  clock, rising edge                         |
// |             rst       in   1  asynchronous active-high reset             |
// |             in_valid  in   1  operand valid                              |
// |             in_ready  out  1  unit can accept an operand                 |
// |             in_data   in  16  FP16 operand {sign, exp, mant}             |
// |             out_valid out  1  result valid                               |
// |             out_ready in   1  consumer accepts result                    |
// |             out_data  out 12  FP12 result {sign, exp, mant}              |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fp16_recip_seq
   import fp_pkg::*;
#(
   parameter int QBITS = 8      // 1 integer + 6 fraction + 1 guard
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_data
);

   localparam int               CNT_W    = (QBITS > 1) ? $clog2(QBITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QBITS - 1);

   state_t state;
   state_t state_next;

   // Latched operand
   logic                  op_sign;
   logic [FP16_EXP_W-1:0] op_exp;
   logic [FP16_MAN_W-1:0] op_mant;

   // Divider state. The integer quotient bit is shifted out of the top of
   // quo: it is always 1 for mant != 0 and the mant == 0 case is forced.
   logic [REM_W-1:0] rem;
   logic [DIV_W-1:0] divisor;
   logic [QBITS-2:0] quo;
   logic [CNT_W-1:0] cnt;

   logic [REM_W-1:0] rem_next;
   logic             qbit;

   fp16_t in_op;
   logic  in_special;
   logic  div_last;

   assign in_op      = fp16_t'(in_data);
   assign in_special = (in_op.exp == '0) || (in_op.exp == EXP_ONES);
   assign div_last   = (cnt == CNT_LAST);

   fp_restoring_divstep u_divstep (
      .rem      (rem),
      .divisor  (divisor),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = in_special ? ST_DONE : ST_DIV;
            end
         end
         ST_DIV: begin
            if (div_last) begin
               state_next = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------- Rounding ----------------
   logic [FP12_MAN_W-1:0] q_mant;
   logic                  guard;
   logic                  sticky;
   logic                  round_up;
   logic [FP12_MAN_W:0]   mant_sum;
   logic [FP12_MAN_W-1:0] mant_fin;
   logic [6:0]            exp_fin;     // two's complement, may go to -1
   logic                  underflow;
   fp12_t                 round_res;

   always_comb begin
      q_mant   = quo[FP12_MAN_W:1];
      guard    = quo[0];
      sticky   = |rem;
      round_up = guard && (sticky || q_mant[0]);
      mant_sum = {1'b0, q_mant} + {{FP12_MAN_W{1'b0}}, round_up};
      if (op_mant == '0) begin
         // Exact power of two: quotient is exactly 2.0, which the 1.x
         // quotient register cannot hold, so the result is forced.
         exp_fin  = EXP_RECIP_BASE + 7'd1 - {2'b00, op_exp};
         mant_fin = '0;
      end else begin
         exp_fin  = EXP_RECIP_BASE - {2'b00, op_exp} + {6'b0, mant_sum[FP12_MAN_W]};
         mant_fin = mant_sum[FP12_MAN_W-1:0];
      end
      // No subnormal outputs: a non-positive exponent flushes to signed zero
      underflow      = exp_fin[6] || (exp_fin == '0);
      round_res.sign = op_sign;
      round_res.exp  = underflow ? '0 : exp_fin[FP12_EXP_W-1:0];
      round_res.mant = underflow ? '0 : mant_fin;
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_sign  <= 1'b0;
         op_exp   <= '0;
         op_mant  <= '0;
         rem      <= '0;
         divisor  <= '0;
         quo      <= '0;
         cnt      <= '0;
         out_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_sign <= in_op.sign;
                  op_exp  <= in_op.exp;
                  op_mant <= in_op.mant;
                  rem     <= REM_INIT;
                  divisor <= {1'b1, in_op.mant};
                  quo     <= '0;
                  cnt     <= '0;
                  if (in_special) begin
                     out_data <= fp12_special(in_op);
                  end
               end
            end
            ST_DIV: begin
               rem <= rem_next;
               quo <= {quo[QBITS-3:0], qbit};
               cnt <= cnt + CNT_W'(1);
            end
            ST_ROUND: begin
               out_data <= round_res;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp16_recip_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_fp16_recip_seq                                           |
// | Purpose   : Self-checking bench for fp16_recip_seq: directed vectors,    |
// |             reset/backpressure scenarios and randomized operands checked |
// |             against an arithmetic reciprocal model and scoreboard.       |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fp16_recip_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int bp_mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random

   typedef struct {
      logic [11:0] res;
      int          lat;
      int          t;
   } ent_t;
   ent_t exp_q[$];

   localparam int NDIR = 10;
   logic [15:0] dir_in  [0:NDIR-1] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4240, 16'h0000,
                                       16'h8001, 16'hFC00, 16'h7E00, 16'h7800, 16'h7BFF};
   logic [11:0] dir_out [0:NDIR-1] = '{12'h3C0, 12'h380, 12'h355, 12'h352, 12'h7C0,
                                       12'hFC0, 12'h800, 12'h7E0, 12'h000, 12'h000};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp16_recip_seq #(.QBITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Reciprocal of an FP16 value, rounded to nearest-even in FP12.
   function automatic logic [11:0] model(input logic [15:0] x);
      int   e, m, d, q, r, mant, ex;
      logic s;
      s = x[15];
      e = int'(x[14:10]);
      m = int'(x[9:0]);
      if (e == 0)  return {s, 5'h1F, 6'h00};
      if (e == 31) return (m == 0) ? {s, 11'h000} : {s, 5'h1F, 6'h20};
      d  = 1024 + m;           // 1.m scaled by 2^10
      q  = (1 << 18) / d;      // 2/1.m scaled by 2^7
      r  = (1 << 18) % d;
      ex = 29 - e;             // 1/x = (2/1.m) * 2^(14-e)
      if (q >= 256) begin      // quotient exactly 2.0
         q  = q / 2;
         ex = ex + 1;
      end
      mant = (q / 2) % 64;
      if ((q % 2 == 1) && (r != 0 || mant % 2 == 1)) mant = mant + 1;
      if (mant == 64) begin
         mant = 0;
         ex   = ex + 1;
      end
      if (ex <= 0) return {s, 11'h000};
      return {s, 5'(ex), 6'(mant)};
   endfunction

   function automatic bit is_special(input logic [15:0] x);
      return (x[14:10] == 5'd0) || (x[14:10] == 5'd31);
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 9))
         0: x[14:10] = 5'd0;
         1: x[14:10] = 5'd31;
         2: x[9:0]   = 10'd0;
         3: x[14:10] = 5'd30;
         4: x[14:10] = 5'd29;
         5: x[9:0]   = 10'h3FF;
         default: ;
      endcase
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic send(input logic [15:0] x);
      int n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = x;
      @(negedge clk);
      while (!in_ready && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!out_valid) chk({nm, "_timeout"}, 32'(out_valid), 32'd1);
   endtask

   task automatic run_one(input logic [15:0] x, input logic [11:0] lit);
      send(x);
      wait_valid($sformatf("dir_%h", x));
      chk($sformatf("dir_%h", x), 32'(out_data), 32'(lit));
   endtask

   // out_ready driver
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Compare process: scoreboard, latency, hold-stability and busy checks
   initial begin
      logic        pv;
      logic [11:0] pd;
      pv = 1'b0;
      pd = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (in_valid && in_ready)
               exp_q.push_back('{model(in_data), is_special(in_data) ? 1 : 10, cyc});
            if (out_valid) begin
               chk("busy_in_ready", 32'(in_ready), 32'd0);
               if (pv)
                  chk("hold_data", 32'(out_data), 32'(pd));
               else if (exp_q.size() == 0)
                  chk("spurious_valid", 32'(out_valid), 32'd0);
               else
                  chk("latency", 32'(cyc - exp_q[0].t), 32'(exp_q[0].lat));
               if (out_ready && exp_q.size() != 0) begin
                  chk("result", 32'(out_data), 32'(exp_q[0].res));
                  void'(exp_q.pop_front());
               end
            end
            pv = out_valid && !out_ready;
            pd = out_data;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   // Main stimulus
   initial begin
      int n;
      int highs;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;

      // Model pinned to hand-computed values
      for (int i = 0; i < NDIR; i++)
         chk($sformatf("model_%h", dir_in[i]), 32'(model(dir_in[i])), 32'(dir_out[i]));

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_data",  32'(out_data),  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors
      for (int i = 0; i < NDIR; i++) run_one(dir_in[i], dir_out[i]);

      // Backpressure: hold out_ready low while a second operand waits
      bp_mode = 1;
      send(16'h4200);
      wait_valid("bp1");
      chk("bp_first", 32'(out_data), 32'h355);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 16'h4240;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_data", 32'(out_data), 32'h355);
      end
      bp_mode = 0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("bp_second_taken", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid("bp2");
      chk("bp_second", 32'(out_data), 32'h352);

      // Reset in the middle of division
      send(16'h3C00);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_in_ready",  32'(in_ready),  32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      highs = 0;
      repeat (14) begin
         @(negedge clk);
         if (out_valid) highs++;
      end
      chk("midrst_no_valid", 32'(highs), 32'd0);
      run_one(16'h4000, 12'h380);

      // Randomized operands with random backpressure
      bp_mode = 2;
      for (int i = 0; i < 250; i++) begin
         send(rand_op());
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      bp_mode = 0;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
